dsp_mac_sequencer: RTL
======================

Name: dsp_mac_sequencer

Overview:
- Upstream controller for the DSP48A1 slice. Accepts a stream of (a, b) operand pairs with valid/ready handshaking and drives the slice's A, B and OPMODE inputs so the slice computes a dot product (sum of a*b) per vector.
- Waits out the slice pipeline, captures P and presents one result per vector on a valid/ready output.
- Targets the slice configured with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", with every CE tied high.

Parameters:
- DSP_LATENCY, 3: clock edges from the operand-issue edge to the edge at which dsp_P holds the updated sum.
- OPMODE_LAG, 1: cycles dsp_OPMODE trails its operands, so it reaches the post-adder with the matching product.
- MAX_LEN, 256: maximum elements per vector.
- CNT_W, 9: element counter width, covering 0..MAX_LEN.

Ports:
- clk  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  18  multiplier operand A.
- in_b  in  18  multiplier operand B.
- in_last  in  1  marks the final element of a vector.
- dsp_A  out  18  to slice A.
- dsp_B  out  18  to slice B.
- dsp_OPMODE  out  8  to slice OPMODE.
- dsp_P  in  48  from slice P.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  48  captured dot product.
- res_count  out  CNT_W  elements in the vector.
- res_trunc  out  1  vector force-terminated at MAX_LEN.

Behaviour:
- Reset: FSM=IDLE; counters, res_valid, res_data, res_count, res_trunc and every OPMODE lag stage = 0; in_ready=0 while RST is high.
- Issue: a handshake (in_valid && in_ready) is an issue edge.
  - dsp_A/dsp_B are combinational: in_a/in_b during a handshake, else 0.
- OPMODE codes before the lag stages:
  - First element of a vector: 8'h01 (X=M, Z=0: P=M).
  - Later elements: 8'h09 (X=M, Z=P: P=P+M).
  - No handshake: 8'h08 (X=0, Z=P: P held).
  - dsp_OPMODE is the code delayed by OPMODE_LAG registers.
- FSM:
  - IDLE: in_ready=1. A handshake moves to ACCUM, count=1.
  - ACCUM: in_ready=1. Each handshake increments count; in_valid gaps issue the hold code.
  - ACCUM exit: a handshake with in_last, or with count reaching MAX_LEN, moves to DRAIN and loads the wait counter with DSP_LATENCY. res_trunc = reaching MAX_LEN without in_last.
  - DRAIN: in_ready=0, hold code issued. The counter decrements each edge. On the edge DSP_LATENCY after the last issue edge, dsp_P is registered into res_data and the FSM moves to HOLD.
  - HOLD: res_valid=1, with res_data/res_count/res_trunc stable. When res_ready=1, res_valid drops at the next edge and the FSM returns to IDLE.
- Next vector: in_ready rises only after the result is accepted; there is no overlap between vectors.
- Single-element vector (first element carries in_last): code 8'h01, goes straight to DRAIN.
- Arithmetic: 48-bit sum as produced by the slice; no saturation inside this block.
- Reset mid-vector: immediate return to IDLE; partial sum discarded, no result emitted.

Decomposition:
- Shared package dsp_pkg:
  - OPMODE constants OPM_LOAD_M=8'h01, OPM_ACC_M=8'h09, OPM_HOLD=8'h08.
  - FSM state enum {IDLE, ACCUM, DRAIN, HOLD}.
  - Default latency parameters.
- Sub-module dsp_opmode_delay: an OPMODE_LAG-deep, 8-bit shift register with async reset, reused wherever control must be aligned with the slice pipeline.

Test Plan:
- Vector (2,3),(4,5),(6,7), in_last on the third, res_ready=1 -> res_data=68, res_count=3, res_trunc=0; res_valid rises exactly 3 edges after the last handshake.
- Same vector with in_valid low for 2 cycles between elements -> still 68; dsp_OPMODE shows 8'h08 in the gaps.
- Single element (50,20) with in_last -> res_data=1000, res_count=1.
- MAX_LEN=4 build, 5 elements of (1,1) with no in_last -> res_data=4, res_count=4, res_trunc=1; in_ready=0 from the 4th handshake until the result is accepted.
- res_ready held 0 for 5 cycles -> res_valid and res_data stable, in_ready=0; a second vector (10,10) afterwards yields res_data=100 (previous sum cleared).
- RST pulsed during ACCUM after 2 elements -> no res_valid; all outputs 0; the next vector (3,3) yields res_data=9.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants for the DSP48A1 MAC sequencer: OPMODE codes, FSM states
// and default slice-pipeline parameters.
package dsp_pkg;

   localparam logic [7:0] OPM_LOAD_M = 8'h01;  // X=M, Z=0
   localparam logic [7:0] OPM_ACC_M  = 8'h09;  // X=M, Z=P
   localparam logic [7:0] OPM_HOLD   = 8'h08;  // X=0, Z=P

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

   localparam int DEF_DSP_LATENCY = 3;
   localparam int DEF_OPMODE_LAG  = 1;
   localparam int DEF_MAX_LEN     = 256;
   localparam int DEF_CNT_W       = 9;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand stream, DSP slice and result buses of the MAC sequencer.
interface dsp_mac_sequencer_if #(
   parameter int CNT_W = 9
);
   logic              in_valid;
   logic              in_ready;
   logic [17:0]       in_a;
   logic [17:0]       in_b;
   logic              in_last;
   logic [17:0]       dsp_A;
   logic [17:0]       dsp_B;
   logic [7:0]        dsp_OPMODE;
   logic [47:0]       dsp_P;
   logic              res_valid;
   logic              res_ready;
   logic [47:0]       res_data;
   logic [CNT_W-1:0]  res_count;
   logic              res_trunc;

   modport master (
      input  in_valid, in_a, in_b, in_last, dsp_P, res_ready,
      output in_ready, dsp_A, dsp_B, dsp_OPMODE, res_valid, res_data, res_count, res_trunc
   );

   modport slave (
      output in_valid, in_a, in_b, in_last, dsp_P, res_ready,
      input  in_ready, dsp_A, dsp_B, dsp_OPMODE, res_valid, res_data, res_count, res_trunc
   );
endinterface

// File: rtl/dsp_opmode_delay.sv
// LAG-deep 8-bit shift register aligning a control code with the slice
// pipeline; LAG=0 is a plain wire.
module dsp_opmode_delay #(
   parameter int LAG = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_code,
   output logic [7:0] o_code
);
   generate
      if (LAG == 0) begin : g_wire
         assign o_code = i_code;
      end else begin : g_pipe
         logic [7:0] r_stage [LAG];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < LAG; i++) r_stage[i] <= '0;
            end else begin
               r_stage[0] <= i_code;
               for (int i = 1; i < LAG; i++) r_stage[i] <= r_stage[i-1];
            end
         end

         assign o_code = r_stage[LAG-1];
      end
   endgenerate
endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives a DSP48A1 slice to accumulate one dot product per operand vector,
// waits out the slice pipeline and presents the captured P on a result port.
module dsp_mac_sequencer
   import dsp_pkg::*;
#(
   parameter int DSP_LATENCY = DEF_DSP_LATENCY,
   parameter int OPMODE_LAG  = DEF_OPMODE_LAG,
   parameter int MAX_LEN     = DEF_MAX_LEN,
   parameter int CNT_W       = DEF_CNT_W
) (
   input logic                 clk,
   input logic                 RST,
   dsp_mac_sequencer_if.master bus
);
   localparam int WAIT_W = $clog2(DSP_LATENCY + 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_count;
   logic [WAIT_W-1:0] r_wait;
   logic [47:0]       r_data;
   logic              r_trunc;

   logic              w_hs;
   logic              w_exit;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [7:0]        w_code;

   assign bus.in_ready = !RST && (r_state == IDLE || r_state == ACCUM);
   assign w_hs         = bus.in_valid && bus.in_ready;
   assign bus.dsp_A    = w_hs ? bus.in_a : '0;
   assign bus.dsp_B    = w_hs ? bus.in_b : '0;

   assign w_count_nxt  = (r_state == IDLE) ? CNT_W'(1) : r_count + CNT_W'(1);
   assign w_exit       = w_hs && (bus.in_last || w_count_nxt == CNT_W'(MAX_LEN));

   always_comb begin
      w_code = OPM_HOLD;
      if (w_hs) w_code = (r_state == IDLE) ? OPM_LOAD_M : OPM_ACC_M;
   end

   // OPMODE must trail its operands so it meets the matching product at the post-adder
   dsp_opmode_delay #(.LAG(OPMODE_LAG)) u_opm_delay (
      .clk    (clk),
      .rst    (RST),
      .i_code (w_code),
      .o_code (bus.dsp_OPMODE)
   );

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_count <= '0;
         r_wait  <= '0;
         r_data  <= '0;
         r_trunc <= 1'b0;
      end else begin
         case (r_state)
            IDLE, ACCUM: begin
               if (w_hs) begin
                  r_count <= w_count_nxt;
                  if (w_exit) begin
                     r_state <= DRAIN;
                     r_wait  <= WAIT_W'(DSP_LATENCY);
                     r_trunc <= !bus.in_last;
                  end else begin
                     r_state <= ACCUM;
                  end
               end
            end
            DRAIN: begin
               r_wait <= r_wait - WAIT_W'(1);
               // r_wait==1 here means DSP_LATENCY edges have passed since the last issue
               if (r_wait <= WAIT_W'(1)) begin
                  r_data  <= bus.dsp_P;
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               if (bus.res_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.res_valid = (r_state == HOLD);
   assign bus.res_data  = r_data;
   assign bus.res_count = r_count;
   assign bus.res_trunc = r_trunc;
endmodule
